data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: CLR_VAL, 8'h00, value written to every location by the CLEAR command.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: cmd_memory  input  8  command from control unit: 8'h00 IDLE, 8'h01 READ, 8'h02 WRITE, 8'h03 CLEAR; all other values illegal.
REQ-005 Port: addr_memory  input  8  word address, 256 x 8-bit locations.
REQ-006 Port: data_memory  inout  8  shared data bus; driven by the initiator for WRITE, by this block only for READ response.
REQ-007 Port: ack  output  1  one-cycle completion strobe.
REQ-008 Port: err  output  1  illegal-command flag, valid only while ack=1.
REQ-009 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-010 Storage SHALL be 256 x 8-bit registers, addressed directly by the 8-bit address; no wrap logic beyond natural 8-bit overflow.
REQ-011 FSM states SHALL be IDLE, RD, WR, CLR, DONE; busy = (state != IDLE).
REQ-012 Commands SHALL be sampled only in IDLE; cmd_memory, addr_memory and data_memory inputs in any other state are ignored.
REQ-013 IDLE, cmd=8'h00: remain IDLE, no side effects.
REQ-014 IDLE, cmd=READ at edge E0: latch address; go to RD.
REQ-015 RD at edge E1: read register loads mem[latched addr]; go to DONE.
REQ-016 IDLE, cmd=WRITE at edge E0: latch address and data_memory value; go to WR.
REQ-017 WR at edge E1: mem[latched addr] <= latched data; go to DONE.
REQ-018 IDLE, cmd=CLEAR at E0: counter <= 8'h00; go to CLR.
REQ-019 CLR, each edge: mem[counter] <= CLR_VAL, counter increments; on the edge that writes address 8'hFF go to DONE (256 CLR cycles total).
REQ-020 IDLE, illegal cmd at E0: set error flag; go to DONE directly (ack one cycle after E0).
REQ-021 DONE SHALL last exactly one cycle, then IDLE; ack=1 only in DONE (Moore output).
REQ-022 err SHALL be 1 in DONE only when the completed command was illegal; 0 otherwise.
REQ-023 data_memory SHALL be driven with the read register only in DONE following RD; high-impedance in every other state and during reset.
REQ-024 Latency: READ/WRITE ack asserted in the cycle after E1 (2 edges from command); CLEAR ack after 257 edges; illegal ack after 1 edge.
REQ-025 A command present in the DONE cycle SHALL be ignored; the earliest next acceptance is the first edge in IDLE after DONE.
REQ-026 A WRITE followed by a READ of the same address SHALL return the newly written data (write completes before the read can be accepted).
REQ-027 Back-to-back commands with cmd held constant SHALL execute repeatedly, one per (latency + 1 IDLE edge).

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, ack=0, err=0, busy=0, counter=0, read register=0, data_memory high-impedance.
REQ-029 Memory contents SHALL NOT be cleared by reset; only CLEAR writes them.
REQ-030 Reset during CLR SHALL abort the sweep; locations already written keep CLR_VAL, remaining locations unchanged.
REQ-031 Reset during WR before E1 SHALL leave the target location unchanged.
REQ-032 After rst_n deasserts, the first rising edge SHALL be able to accept a command.

Verification
REQ-033 WRITE addr 8'h10 data 8'hA5, then READ 8'h10 -> ack 2 edges after each command, err=0, data_memory=8'hA5 in read DONE cycle, high-Z otherwise.
REQ-034 CLEAR with CLR_VAL=8'h00 after writes to 8'h00 and 8'hFF -> busy 257 cycles, one ack, subsequent READs of 8'h00 and 8'hFF return 8'h00.
REQ-035 cmd=8'h7E -> ack and err both high exactly one cycle after command edge; memory unchanged.
REQ-036 READ issued, then cmd=WRITE held through RD and DONE -> write ignored until IDLE, then executes once per accept; no bus contention in DONE.
REQ-037 Reset asserted mid-CLEAR at counter=8'h40 -> outputs reset asynchronously, locations 8'h00-8'h3F = CLR_VAL, 8'h40 and above retain prior data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Command-driven 256 x 8 data memory with READ/WRITE/CLEAR handshake.
// A control unit issues one command per IDLE cycle; the block answers with a
// one-cycle ack (plus err for illegal opcodes) and drives the shared data bus
// only while presenting read data.
module data_mem_responder #(
  parameter logic [7:0] CLR_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cmd_memory,
  input  logic [7:0] addr_memory,
  inout  wire  [7:0] data_memory,
  output logic       ack,
  output logic       err,
  output logic       busy
);

  localparam logic [7:0] CMD_IDLE  = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_CLEAR = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_CLR,
    ST_DONE
  } state_t;

  state_t     state_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] cnt_q;
  logic [7:0] rdata_q;
  logic       ack_q;
  logic       err_q;
  logic       busy_q;
  logic       drive_q;

  // Storage is deliberately not reset: only CLEAR may change its contents.
  logic [7:0] mem [256];

  logic       mem_we_d;
  logic [7:0] mem_waddr_d;
  logic [7:0] mem_wdata_d;

  // Write port select: single write in WR, sweep write in CLR.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = addr_q;
    mem_wdata_d = wdata_q;
    if (state_q == ST_WR) begin
      mem_we_d = 1'b1;
    end else if (state_q == ST_CLR) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = cnt_q;
      mem_wdata_d = CLR_VAL;
    end
  end

  // Memory write; reset forces IDLE asynchronously so an aborted WR/CLR writes nothing more.
  always_ff @(posedge clk) begin
    if (mem_we_d) begin
      mem[mem_waddr_d] <= mem_wdata_d;
    end
  end

  // Control FSM with registered Moore outputs (ack/err/busy/bus enable).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      cnt_q   <= 8'h00;
      rdata_q <= 8'h00;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      drive_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          case (cmd_memory)
            CMD_IDLE: ;
            CMD_READ: begin
              addr_q  <= addr_memory;
              busy_q  <= 1'b1;
              state_q <= ST_RD;
            end
            CMD_WRITE: begin
              addr_q  <= addr_memory;
              wdata_q <= data_memory;
              busy_q  <= 1'b1;
              state_q <= ST_WR;
            end
            CMD_CLEAR: begin
              cnt_q   <= 8'h00;
              busy_q  <= 1'b1;
              state_q <= ST_CLR;
            end
            default: begin
              err_q   <= 1'b1;
              ack_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          endcase
        end
        ST_RD: begin
          rdata_q <= mem[addr_q];
          ack_q   <= 1'b1;
          drive_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_WR: begin
          ack_q   <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_CLR: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'hFF) begin
            ack_q   <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          drive_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          drive_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data_memory = drive_q ? rdata_q : 8'bzzzz_zzzz;
  assign ack         = ack_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: the driver pushes the expected
// response of each command, a negedge monitor pops it on every ack.
module tb_data_mem_responder;

  localparam logic [7:0] C_IDLE  = 8'h00;
  localparam logic [7:0] C_READ  = 8'h01;
  localparam logic [7:0] C_WRITE = 8'h02;
  localparam logic [7:0] C_CLEAR = 8'h03;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic [7:0] addr = 8'h00;
  logic [7:0] tb_data = 8'h00;
  logic       tb_drive = 1'b0;
  logic       hold_wr = 1'b0;
  logic       drive_en;
  logic       ack, err, busy;
  wire  [7:0] data_bus;

  typedef struct packed {
    logic       err;
    logic       is_rd;
    logic [7:0] rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Initiator releases the bus whenever the responder is busy.
  assign drive_en = tb_drive | (hold_wr & ~busy);
  assign data_bus = drive_en ? tb_data : 8'bzzzz_zzzz;

  // Weak pull-ups make a released bus read as 8'hFF.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pu
    pullup (data_bus[gi]);
  end

  data_mem_responder #(.CLR_VAL(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_memory (cmd),
    .addr_memory(addr),
    .data_memory(data_bus),
    .ack        (ack),
    .err        (err),
    .busy       (busy)
  );

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: pop one expectation per ack; otherwise the bus must be released.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ack) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack_err", int'(err), int'(e.err));
        if (e.is_rd) chk("read_data", int'(data_bus), int'(e.rd));
        else if (!drive_en) chk("bus_hiz_ack", int'(data_bus), 8'hFF);
        $display("ack cmd_err=%0b rd=%0b data=%02h", err, e.is_rd, data_bus);
      end
    end else if (!drive_en) begin
      checks++;
      if (data_bus !== 8'hFF) begin
        errors++;
        $display("FAIL bus_hiz actual=%02h required=ff at %0t", data_bus, $time);
      end
    end
  end

  // Issue one command and check ack latency and busy duration (both = lat edges).
  task automatic do_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                        input int lat, input bit exp_err, input bit is_rd, input logic [7:0] rd);
    int  n;
    int  busy_n;
    bit  seen;
    exp_q.push_back('{err: exp_err, is_rd: is_rd, rd: rd});
    @(negedge clk);
    cmd = c; addr = a; tb_data = d; tb_drive = (c == C_WRITE);
    @(posedge clk); #1;
    cmd = C_IDLE; tb_drive = 1'b0;
    n = 1; busy_n = 0; seen = 0;
    for (int k = 0; k < 400; k++) begin
      if (busy) busy_n++;
      if (ack && !seen) begin
        seen = 1;
        chk("ack_latency", n, lat);
      end
      if (!busy) break;
      @(posedge clk); #1;
      n++;
    end
    if (!seen) chk("ack_timeout", 0, 1);
    chk("busy_cycles", busy_n, lat);
  endtask

  // Start a command, then assert reset after extra_edges more edges.
  task automatic abort_cmd(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input int extra_edges);
    @(negedge clk);
    cmd = c; addr = a; tb_data = d; tb_drive = (c == C_WRITE);
    @(posedge clk); #1;
    cmd = C_IDLE; tb_drive = 1'b0;
    repeat (extra_edges) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_ack", int'(ack), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_bus", int'(data_bus), 8'hFF);
    $display("abort cmd=%02h after %0d edges", c, extra_edges);
    @(posedge clk); #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    #1;
    chk("rst_ack", int'(ack), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_bus", int'(data_bus), 8'hFF);
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;

    // Write then read back, both two edges to ack.
    do_cmd(C_WRITE, 8'h10, 8'hA5, 2, 0, 0, 8'h00);
    do_cmd(C_READ,  8'h10, 8'h00, 2, 0, 1, 8'hA5);
    // Illegal opcode: ack+err after one edge, memory untouched.
    do_cmd(8'h7E,   8'h10, 8'h00, 1, 1, 0, 8'h00);
    do_cmd(8'hFF,   8'h10, 8'h00, 1, 1, 0, 8'h00);
    do_cmd(C_READ,  8'h10, 8'h00, 2, 0, 1, 8'hA5);
    // CLEAR sweep of 257 edges wipes both ends of the array.
    do_cmd(C_WRITE, 8'h00, 8'h5C, 2, 0, 0, 8'h00);
    do_cmd(C_WRITE, 8'hFF, 8'hC5, 2, 0, 0, 8'h00);
    do_cmd(C_READ,  8'h00, 8'h00, 2, 0, 1, 8'h5C);
    do_cmd(C_READ,  8'hFF, 8'h00, 2, 0, 1, 8'hC5);
    do_cmd(C_CLEAR, 8'h00, 8'h00, 257, 0, 0, 8'h00);
    do_cmd(C_READ,  8'h00, 8'h00, 2, 0, 1, 8'h00);
    do_cmd(C_READ,  8'hFF, 8'h00, 2, 0, 1, 8'h00);

    // READ followed by WRITE held through RD/DONE: acks at edges 2, 5, 8.
    do_cmd(C_WRITE, 8'h30, 8'h9C, 2, 0, 0, 8'h00);
    exp_q.push_back('{err: 1'b0, is_rd: 1'b1, rd: 8'h9C});
    exp_q.push_back('{err: 1'b0, is_rd: 1'b0, rd: 8'h00});
    exp_q.push_back('{err: 1'b0, is_rd: 1'b0, rd: 8'h00});
    @(negedge clk);
    cmd = C_READ; addr = 8'h30;
    @(posedge clk); #1;
    cmd = C_WRITE; addr = 8'h31; tb_data = 8'h77; hold_wr = 1'b1;
    pat = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      pat[k] = ack;
    end
    cmd = C_IDLE; hold_wr = 1'b0;
    chk("held_ack_pattern", int'(pat), 8'b1001_0010);
    $display("held write ack pattern=%08b", pat);
    repeat (2) @(posedge clk);
    do_cmd(C_READ, 8'h31, 8'h00, 2, 0, 1, 8'h77);
    do_cmd(C_READ, 8'h30, 8'h00, 2, 0, 1, 8'h9C);

    // Reset before the WR edge leaves the location unchanged.
    do_cmd(C_WRITE, 8'h20, 8'h5A, 2, 0, 0, 8'h00);
    abort_cmd(C_WRITE, 8'h20, 8'hC3, 0);
    do_cmd(C_READ, 8'h20, 8'h00, 2, 0, 1, 8'h5A);

    // Reset with the sweep counter at 8'h40: 00-3F cleared, 40+ kept.
    do_cmd(C_WRITE, 8'h3F, 8'h11, 2, 0, 0, 8'h00);
    do_cmd(C_WRITE, 8'h40, 8'h22, 2, 0, 0, 8'h00);
    do_cmd(C_WRITE, 8'hFF, 8'h33, 2, 0, 0, 8'h00);
    abort_cmd(C_CLEAR, 8'h00, 8'h00, 64);
    do_cmd(C_READ, 8'h00, 8'h00, 2, 0, 1, 8'h00);
    do_cmd(C_READ, 8'h3F, 8'h00, 2, 0, 1, 8'h00);
    do_cmd(C_READ, 8'h40, 8'h00, 2, 0, 1, 8'h22);
    do_cmd(C_READ, 8'hFF, 8'h00, 2, 0, 1, 8'h33);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
